load_store_unit: RTL and testbench

Sits between the execute-stage ALU/register-file outputs and the word-wide data memory. It converts RV32I byte/halfword/word loads and stores into whole-word memory accesses. The data memory has no byte enables, so sub-word stores are done as a two-cycle read-modify-write (RMW) with a pipeline stall. Loads are returned sign- or zero-extended in the same cycle.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Converts RV32I byte/halfword/word loads and stores into whole-word accesses
// on a data memory that has no byte enables. Loads are extracted and sign- or
// zero-extended in the same cycle from the combinational read data. Word
// stores go straight through. Sub-word stores become a two-cycle
// read-modify-write: the first cycle reads the target word, merges the new
// lane(s) and stalls upstream; the second cycle writes the merged word.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   MemRead     load request this cycle
//   MemWrite    store request this cycle (wins over MemRead)
//   funct3      RV32I width/sign code
//   ALUresult   byte address
//   WriteData   store data, low-order lanes used for sub-word stores
//   ReadData    extended load result (0 when no legal load is decoded)
//   stall       upstream must hold its request and not advance
//   access_err  misaligned or illegal-funct3 access this cycle
//   mem_addr    word index to memory = {2'b00, addr[31:2]}
//   mem_wen     memory write enable
//   mem_wdata   word written to memory
//   mem_rdata   combinational read data for mem_addr
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUresult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  stall,
    output logic                  access_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // The lane logic below is written for a 32-bit word; ADDRESS_WIDTH only
    // matters to the memory, which truncates the word index itself.
    if (DATA_WIDTH != 32 || ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > DATA_WIDTH - 2)
    begin : g_bad_params
        $error("load_store_unit: unsupported DATA_WIDTH/ADDRESS_WIDTH");
    end

    localparam logic StIdle  = 1'b0;
    localparam logic StWrite = 1'b1;

    logic                  state_q, state_d;
    logic [DATA_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;

    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] word_idx;
    logic                  load_ok, store_ok;
    logic                  is_store, is_load, in_idle;
    logic                  word_store, sub_store, load_go;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    assign lane     = ALUresult[1:0];
    assign word_idx = {2'b00, ALUresult[DATA_WIDTH-1:2]};

    // Width/alignment legality per funct3, separately for loads and stores.
    always_comb begin
        load_ok  = 1'b0;
        store_ok = 1'b0;
        case (funct3)
            3'b000: begin
                load_ok  = 1'b1;
                store_ok = 1'b1;
            end
            3'b001: begin
                load_ok  = ~lane[0];
                store_ok = ~lane[0];
            end
            3'b010: begin
                load_ok  = (lane == 2'b00);
                store_ok = (lane == 2'b00);
            end
            3'b100:  load_ok = 1'b1;
            3'b101:  load_ok = ~lane[0];
            default: ;
        endcase
    end

    // A simultaneous read and write is treated purely as a store.
    assign is_store = MemWrite;
    assign is_load  = MemRead & ~MemWrite;
    // New requests are only decoded in IDLE and never during reset.
    assign in_idle  = (state_q == StIdle) & ~rst;

    assign word_store = in_idle & is_store & store_ok & (funct3[1:0] == 2'b10);
    assign sub_store  = in_idle & is_store & store_ok & (funct3[1:0] != 2'b10);
    assign load_go    = in_idle & is_load & load_ok;

    assign access_err = in_idle & ((is_store & ~store_ok) | (is_load & ~load_ok));

    // Load lane extraction and extension.
    assign byte_sel = mem_rdata[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = '0;
        case (funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'b0, byte_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = '0;
        endcase
    end

    assign ReadData = load_go ? load_data : '0;

    // Read-modify-write merge: current word with the target lane(s) replaced.
    always_comb begin
        merged = mem_rdata;
        if (funct3[0]) begin
            if (lane[1]) begin
                merged[31:16] = WriteData[15:0];
            end else begin
                merged[15:0] = WriteData[15:0];
            end
        end else begin
            merged[{lane, 3'b000} +: 8] = WriteData[7:0];
        end
    end

    // Memory-side outputs; the WRITE cycle replays the latched address/word.
    assign mem_addr  = (state_q == StWrite) ? lat_addr_q  : word_idx;
    assign mem_wdata = (state_q == StWrite) ? lat_wdata_q : WriteData;
    assign mem_wen   = ~rst & ((state_q == StWrite) | word_store);
    assign stall     = sub_store;

    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        if (state_q == StWrite) begin
            state_d = StIdle;
        end else if (sub_store) begin
            state_d     = StWrite;
            lat_addr_d  = word_idx;
            lat_wdata_d = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit against a 256-word harness memory. Expected values
// come from a byte-addressable reference memory (1 KiB, little-endian) updated
// per transaction. Directed scenarios first, then randomized operations.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUresult, WriteData;
    logic [31:0] ReadData;
    logic        stall, access_err, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_words [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    logic [7:0]  ref_bytes [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .ALUresult (ALUresult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .stall     (stall),
        .access_err(access_err),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Harness memory: combinational read, write at the rising edge.
    assign mem_rdata = mem_words[mem_addr[7:0]];

    always @(posedge clk) begin
        if (bd_we) begin
            mem_words[bd_idx] <= bd_data;
        end else if (mem_wen) begin
            mem_words[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic store_legal(input logic [2:0] f3, input logic [31:0] a);
        if (f3 > 3'd2) return 1'b0;
        return (a % width_of(f3)) == 0;
    endfunction

    function automatic logic load_legal(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (a % width_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [9:0] b);
        logic [31:0] v;
        int base;
        base = int'(b) & ~3;
        v = '0;
        for (int i = 0; i < 4; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [31:0] load_exp(input logic [2:0] f3, input logic [9:0] b);
        logic [31:0] v;
        int n;
        n = width_of(f3);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(b) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic set_idle();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'b000;
        ALUresult = '0;
        WriteData = '0;
    endtask

    task automatic backdoor(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        set_idle();
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        for (int i = 0; i < 4; i++) ref_bytes[int'(idx) * 4 + i] = data[8 * i +: 8];
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One transaction: drive at the falling edge, check #1 later; a legal
    // sub-word store is followed through its second cycle with inputs held.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd_obs, output logic [31:0] wr_obs);
        logic       legal, is_store, is_load, req;
        logic [9:0] b;
        int         n;
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        ALUresult = addr;
        WriteData = wd;
        #1;
        is_store = wr;
        is_load  = rd & ~wr;
        req      = rd | wr;
        n        = width_of(f3);
        legal    = is_store ? store_legal(f3, addr) : load_legal(f3, addr);
        b        = addr[9:0];
        rd_obs   = ReadData;
        wr_obs   = mem_wdata;
        chk("mem_addr", mem_addr, {2'b00, addr[31:2]});
        chk1("access_err", access_err, req & ~legal);
        if (is_store && legal && n == 4) begin
            chk1("sw_stall", stall, 1'b0);
            chk1("sw_wen", mem_wen, 1'b1);
            chk("sw_wdata", mem_wdata, wd);
            chk("sw_rdata", ReadData, 32'h0);
            for (int i = 0; i < 4; i++) ref_bytes[int'(b) + i] = wd[8 * i +: 8];
        end else if (is_store && legal) begin
            chk1("rmw1_stall", stall, 1'b1);
            chk1("rmw1_wen", mem_wen, 1'b0);
            chk("rmw1_rdata", ReadData, 32'h0);
            for (int i = 0; i < n; i++) ref_bytes[int'(b) + i] = wd[8 * i +: 8];
            @(negedge clk);
            #1;
            wr_obs = mem_wdata;
            chk1("rmw2_stall", stall, 1'b0);
            chk1("rmw2_wen", mem_wen, 1'b1);
            chk1("rmw2_err", access_err, 1'b0);
            chk("rmw2_rdata", ReadData, 32'h0);
            chk("rmw2_addr", mem_addr, {2'b00, addr[31:2]});
            chk("rmw2_wdata", mem_wdata, ref_word(b));
        end else if (is_load && legal) begin
            chk1("ld_stall", stall, 1'b0);
            chk1("ld_wen", mem_wen, 1'b0);
            chk("ld_data", ReadData, load_exp(f3, b));
        end else begin
            chk1("nop_stall", stall, 1'b0);
            chk1("nop_wen", mem_wen, 1'b0);
            chk("nop_rdata", ReadData, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] r, w;
        logic [31:0] addr;
        int          kind;
        logic [2:0]  f3;

        rst   = 1'b1;
        bd_we = 1'b0;
        bd_idx  = '0;
        bd_data = '0;
        set_idle();

        for (int i = 0; i < 256; i++) backdoor(8'(i), $urandom);

        // Requests during reset are suppressed.
        @(negedge clk);
        MemWrite = 1'b1; funct3 = 3'b000; ALUresult = 32'h12; WriteData = 32'hAB;
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_wen", mem_wen, 1'b0);
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1; funct3 = 3'b011; ALUresult = 32'h11;
        #1;
        chk1("rst_err", access_err, 1'b0);
        chk("rst_rdata", ReadData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();

        // Word path.
        do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, r, w);
        do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, w);
        chk("lw_const", r, 32'hDEAD_BEEF);

        // SB read-modify-write.
        backdoor(8'd4, 32'h1122_3344);
        do_op(1'b0, 1'b1, 3'b000, 32'h12, 32'h0000_00AB, r, w);
        chk("sb_merge", w, 32'h11AB_3344);
        do_op(1'b1, 1'b0, 3'b000, 32'h12, 32'h0, r, w);
        chk("lb_const", r, 32'hFFFF_FFAB);
        do_op(1'b1, 1'b0, 3'b100, 32'h12, 32'h0, r, w);
        chk("lbu_const", r, 32'h0000_00AB);

        // SH upper half.
        backdoor(8'd4, 32'h1122_3344);
        do_op(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_8001, r, w);
        chk("sh_merge", w, 32'h8001_3344);
        do_op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, r, w);
        chk("lh_const", r, 32'hFFFF_8001);
        do_op(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, r, w);
        chk("lhu_const", r, 32'h0000_8001);

        // Illegal accesses.
        do_op(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, r, w);
        do_op(1'b0, 1'b1, 3'b010, 32'h12, 32'hCAFE_F00D, r, w);
        do_op(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, r, w);
        do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, w);
        chk("err_no_write", r, 32'h8001_3344);

        // Back-to-back sub-word stores into one word.
        backdoor(8'd4, 32'h1122_3344);
        do_op(1'b0, 1'b1, 3'b000, 32'h10, 32'h0000_005A, r, w);
        do_op(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00C3, r, w);
        chk("b2b_merge", w, 32'h1122_C35A);

        // Reset while in WRITE aborts the store.
        backdoor(8'd4, 32'h1122_3344);
        @(negedge clk);
        MemWrite = 1'b1; funct3 = 3'b000; ALUresult = 32'h12; WriteData = 32'h55;
        #1;
        chk1("abort_stall1", stall, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk1("abort_wen", mem_wen, 1'b0);
            chk1("abort_stall", stall, 1'b0);
            chk1("abort_err", access_err, 1'b0);
            chk("abort_rdata", ReadData, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, w);
        chk("abort_unchanged", r, 32'h1122_3344);

        // Randomized operations.
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 9);
            f3   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) addr = addr & ~32'h3;
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FC00);
            if (kind == 0)      do_op(1'b0, 1'b0, f3, addr, $urandom, r, w);
            else if (kind < 5)  do_op(1'b1, 1'b0, f3, addr, $urandom, r, w);
            else if (kind < 9)  do_op(1'b0, 1'b1, f3, addr, $urandom, r, w);
            else                do_op(1'b1, 1'b1, f3, addr, $urandom, r, w);
        end

        @(negedge clk);
        set_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
